// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store path to the word-organised data memory.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MERGE = 1'b1;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] lane;
    } lane_sel_t;

    function automatic logic is_fault(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic f;
        f = 1'b0;
        unique case (1'b1)
            (size == SZ_BYTE): f = 1'b0;
            (size == SZ_HALF): f = lo[0];
            (size == SZ_WORD): f = |lo;
            default:           f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane select/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_ld_word,
    input  lane_sel_t   i_ld_sel,
    input  logic        i_ld_signed,
    output logic [31:0] o_ld_data,
    input  logic [31:0] i_st_old,
    input  logic [31:0] i_st_new,
    input  lane_sel_t   i_st_sel,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_word[{i_ld_sel.lane, 3'b000} +: 8];
        w_half = i_ld_sel.lane[1] ? i_ld_word[31:16]
                                  : i_ld_word[15:0];
        o_ld_data = i_ld_word;
        unique case (1'b1)
            (i_ld_sel.size == SZ_BYTE):
                o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
            (i_ld_sel.size == SZ_HALF):
                o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
            default:
                o_ld_data = i_ld_word;
        endcase
    end

    always_comb begin
        o_st_word = i_st_old;
        unique case (1'b1)
            (i_st_sel.size == SZ_BYTE):
                o_st_word[{i_st_sel.lane, 3'b000} +: 8] = i_st_new[7:0];
            (i_st_sel.size == SZ_HALF): begin
                if (i_st_sel.lane[1])
                    o_st_word[31:16] = i_st_new[15:0];
                else
                    o_st_word[15:0] = i_st_new[15:0];
            end
            default:
                o_st_word = i_st_new;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory;
// sub-word stores use a two-cycle read-modify-write.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_signed,
    input  logic [ADDR_WIDTH+1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_fault,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    lane_sel_t             r_sel;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_resp_valid;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_merge;
    logic                  w_accept;
    logic                  w_fault;
    logic                  w_word_st;
    lane_sel_t             w_sel;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_merge   = (r_state == ST_MERGE);
    assign o_ready   = (r_state == ST_IDLE);
    assign w_accept  = i_valid && o_ready;
    assign w_fault   = is_fault(i_size, i_addr[1:0]);
    assign w_sel     = '{size: i_size, lane: i_addr[1:0]};
    assign w_word_st = i_we && !w_fault && (i_size == SZ_WORD);

    lsu_lane_align u_align (
        .i_ld_word   (i_mem_rdata),
        .i_ld_sel    (w_sel),
        .i_ld_signed (i_signed),
        .o_ld_data   (w_ld_data),
        .i_st_old    (i_mem_rdata),
        .i_st_new    (r_wdata),
        .i_st_sel    (r_sel),
        .o_st_word   (w_merged)
    );

    // Write enable is gated by reset so an in-flight merge is dropped at once.
    assign o_mem_we = i_rst_n &&
                      (w_merge || (w_accept && w_word_st));
    assign o_mem_addr  = w_merge ? r_addr
                                 : i_addr[ADDR_WIDTH+1:2];
    assign o_mem_wdata = w_merge ? w_merged : i_wdata;

    assign o_resp_valid = r_resp_valid;
    assign o_fault      = r_fault;
    assign o_rdata      = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_fault      <= 1'b0;
            unique case (1'b1)
                w_merge: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b1;
                    r_rdata      <= '0;
                end
                w_accept: begin
                    if (w_fault) begin
                        r_resp_valid <= 1'b1;
                        r_fault      <= 1'b1;
                        r_rdata      <= '0;
                    end else if (!i_we) begin
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_ld_data;
                    end else if (w_word_st) begin
                        r_resp_valid <= 1'b1;
                        r_rdata      <= '0;
                    end else begin
                        r_state <= ST_MERGE;
                        r_addr  <= i_addr[ADDR_WIDTH+1:2];
                        r_sel   <= w_sel;
                        r_wdata <= i_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [6:0]  i_addr;
    logic [31:0] i_wdata;
    logic        o_resp_valid;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic [4:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_we;
    logic [31:0] i_mem_rdata;

    logic [31:0] mem [32];
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_we         (i_we),
        .i_size       (i_size),
        .i_signed     (i_signed),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_resp_valid (o_resp_valid),
        .o_rdata      (o_rdata),
        .o_fault      (o_fault),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_we     (o_mem_we),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge clk) begin
        if (o_mem_we)
            mem[o_mem_addr] <= o_mem_wdata;
        else if (pl_we)
            mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [6:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        i_valid = 1'b1; i_we = we; i_size = sz;
        i_signed = sg; i_addr = a; i_wdata = d;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz,
                           input logic sg, input logic [6:0] a,
                           input logic [31:0] exp);
        drive(1'b0, sz, sg, a, 32'h0);
        #1;
        chk({tag, "_addr"}, {27'h0, o_mem_addr}, {27'h0, a[6:2]});
        chk({tag, "_we"}, {31'h0, o_mem_we}, 32'h0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk({tag, "_rv"}, {31'h0, o_resp_valid}, 32'h1);
        chk({tag, "_flt"}, {31'h0, o_fault}, 32'h0);
        chk({tag, "_rd"}, o_rdata, exp);
    endtask

    task automatic do_fault(input string tag, input logic we,
                            input logic [1:0] sz, input logic [6:0] a);
        drive(we, sz, 1'b0, a, 32'hFFFF_FFFF);
        #1;
        chk({tag, "_we"}, {31'h0, o_mem_we}, 32'h0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk({tag, "_rv"}, {31'h0, o_resp_valid}, 32'h1);
        chk({tag, "_flt"}, {31'h0, o_fault}, 32'h1);
        chk({tag, "_rd"}, o_rdata, 32'h0);
        chk({tag, "_rdy"}, {31'h0, o_ready}, 32'h1);
    endtask

    task automatic do_sub(input string tag, input logic [1:0] sz,
                          input logic [6:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        drive(1'b1, sz, 1'b0, a, d);
        #1;
        chk({tag, "_we0"}, {31'h0, o_mem_we}, 32'h0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk({tag, "_rdy"}, {31'h0, o_ready}, 32'h0);
        chk({tag, "_we1"}, {31'h0, o_mem_we}, 32'h1);
        chk({tag, "_wd"}, o_mem_wdata, exp);
        chk({tag, "_rv1"}, {31'h0, o_resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_mem"}, mem[a[6:2]], exp);
        chk({tag, "_rv2"}, {31'h0, o_resp_valid}, 32'h1);
        chk({tag, "_rd"}, o_rdata, 32'h0);
        chk({tag, "_flt"}, {31'h0, o_fault}, 32'h0);
        chk({tag, "_rdy2"}, {31'h0, o_ready}, 32'h1);
    endtask

    initial begin
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        rst_n = 1'b0;
        i_valid = 1'b1; i_we = 1'b1; i_size = 2'b10;
        i_signed = 1'b0; i_addr = 7'd0; i_wdata = 32'h1234_5678;
        #12;
        chk("rst_rv", {31'h0, o_resp_valid}, 32'h0);
        chk("rst_flt", {31'h0, o_fault}, 32'h0);
        chk("rst_rd", o_rdata, 32'h0);
        chk("rst_we", {31'h0, o_mem_we}, 32'h0);
        chk("rst_rdy", {31'h0, o_ready}, 32'h1);
        i_valid = 1'b0;
        preload(5'd0, 32'hCAFE_BABE);
        preload(5'd1, 32'h0123_4567);
        preload(5'd2, 32'h0000_0000);
        preload(5'd3, 32'h80FF_7F01);
        preload(5'd5, 32'h1122_3344);
        preload(5'd7, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        do_load("ld_sb13", 2'b00, 1'b1, 7'd13, 32'h0000_007F);
        do_load("ld_sb14", 2'b00, 1'b1, 7'd14, 32'hFFFF_FFFF);
        do_load("ld_ub14", 2'b00, 1'b0, 7'd14, 32'h0000_00FF);
        do_load("ld_uh14", 2'b01, 1'b0, 7'd14, 32'h0000_80FF);
        do_load("ld_sh14", 2'b01, 1'b1, 7'd14, 32'hFFFF_80FF);
        do_load("ld_sw12", 2'b10, 1'b1, 7'd12, 32'h80FF_7F01);
        @(posedge clk); #1;
        chk("hold_rv", {31'h0, o_resp_valid}, 32'h0);
        chk("hold_rd", o_rdata, 32'h80FF_7F01);

        drive(1'b1, 2'b10, 1'b0, 7'd8, 32'hDEAD_BEEF);
        #1;
        chk("sw_we", {31'h0, o_mem_we}, 32'h1);
        chk("sw_wd", o_mem_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", {27'h0, o_mem_addr}, 32'h2);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("sw_mem", mem[2], 32'hDEAD_BEEF);
        chk("sw_rv", {31'h0, o_resp_valid}, 32'h1);
        chk("sw_rd", o_rdata, 32'h0);
        chk("sw_rdy", {31'h0, o_ready}, 32'h1);

        do_sub("sb22", 2'b00, 7'd22, 32'h0000_00AA, 32'h11AA_3344);
        do_sub("sh20", 2'b01, 7'd20, 32'h0000_BEEF, 32'h11AA_BEEF);

        do_fault("f_lh5", 1'b0, 2'b01, 7'd5);
        do_fault("f_sw6", 1'b1, 2'b10, 7'd6);
        do_fault("f_rsv", 1'b1, 2'b11, 7'd0);
        chk("f_mem1", mem[1], 32'h0123_4567);
        chk("f_mem0", mem[0], 32'hCAFE_BABE);

        drive(1'b1, 2'b00, 1'b0, 7'd0, 32'h0000_0055);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("ra_we1", {31'h0, o_mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ra_we0", {31'h0, o_mem_we}, 32'h0);
        chk("ra_rv0", {31'h0, o_resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("ra_mem", mem[0], 32'hCAFE_BABE);
        chk("ra_rv1", {31'h0, o_resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ra_rdy", {31'h0, o_ready}, 32'h1);
        @(posedge clk); #1;
        chk("ra_rv2", {31'h0, o_resp_valid}, 32'h0);
        do_load("ra_ld", 2'b10, 1'b0, 7'd0, 32'hCAFE_BABE);

        drive(1'b1, 2'b00, 1'b0, 7'd28, 32'h0000_0011);
        @(posedge clk); #1;
        i_addr = 7'd31; i_wdata = 32'h0000_0022;
        chk("b2b_rdy1", {31'h0, o_ready}, 32'h0);
        chk("b2b_rv1", {31'h0, o_resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_rdy2", {31'h0, o_ready}, 32'h1);
        chk("b2b_rv2", {31'h0, o_resp_valid}, 32'h1);
        chk("b2b_mem1", mem[7], 32'h0000_0011);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("b2b_rdy3", {31'h0, o_ready}, 32'h0);
        chk("b2b_rv3", {31'h0, o_resp_valid}, 32'h0);
        chk("b2b_wd", o_mem_wdata, 32'h2200_0011);
        @(posedge clk); #1;
        chk("b2b_mem2", mem[7], 32'h2200_0011);
        chk("b2b_rv4", {31'h0, o_resp_valid}, 32'h1);
        chk("b2b_rdy4", {31'h0, o_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
